// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues packet-aligned fetch requests, keeps at most
// one request in flight, and buffers returned packets in a small FIFO that
// feeds decode.
// Optional feature: define IFU_PERF_CNT_EN to build the queue-full stall
// counter on perf_stall_cnt; otherwise that port is tied to zero.
//
// state | meaning
// RUN   | idle or requesting; a request issues when the queue has room
// WAIT  | one request outstanding; the next response is pushed to the queue
// KILL  | the outstanding request was redirected; its response is discarded
module inst_fetch_unit #(
    parameter int                FETCH_NUM   = 4,
    parameter int                QUEUE_DEPTH = 4,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_W-1:0]       mem_req_addr,
    input  logic                    mem_resp_valid,
    input  logic [32*FETCH_NUM-1:0] mem_resp_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [32*FETCH_NUM-1:0] out_inst,
    output logic [FETCH_NUM-1:0]    out_mask,
    output logic [ADDR_W-1:0]       out_pc,
    output logic [31:0]             perf_stall_cnt
);
    localparam int OFF_W  = $clog2(FETCH_NUM);
    localparam int LOW_W  = OFF_W + 2;
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int DATA_W = 32 * FETCH_NUM;
    localparam logic [ADDR_W-1:0] PKT_BYTES = ADDR_W'(4 * FETCH_NUM);

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_KILL} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] aligned_pc;
    logic [OFF_W-1:0]  offset_q;
    logic [FETCH_NUM-1:0] resp_mask;

    logic [DATA_W-1:0]    q_data [QUEUE_DEPTH];
    logic [FETCH_NUM-1:0] q_mask [QUEUE_DEPTH];
    logic [ADDR_W-1:0]    q_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    logic req_fire, push, pop;

    assign aligned_pc   = {pc[ADDR_W-1:LOW_W], {LOW_W{1'b0}}};
    assign mem_req_addr = aligned_pc;
    assign out_valid    = (count != '0);
    assign out_inst     = q_data[rd_ptr];
    assign out_mask     = q_mask[rd_ptr];
    assign out_pc       = q_pc[rd_ptr];

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Next-state logic; a redirect always wins over the normal flow
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (req_fire) state_nxt = redirect_valid ? ST_KILL : ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect_valid)      state_nxt = mem_resp_valid ? ST_RUN : ST_KILL;
                else if (mem_resp_valid) state_nxt = ST_RUN;
            end
            ST_KILL: begin
                // the killed response frees the slot even if another redirect lands with it
                if (mem_resp_valid) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs and queue handshakes
    always_comb begin
        mem_req_valid = (state == ST_RUN) && (count < CNT_W'(QUEUE_DEPTH))
                        && !redirect_valid && !reset;
        req_fire      = mem_req_valid && mem_req_ready;
        push          = (state == ST_WAIT) && mem_resp_valid && !redirect_valid;
        pop           = out_valid && out_ready && !redirect_valid;
    end

    // Lane mask: lanes below the entry offset of the packet are not valid
    always_comb begin
        resp_mask = '0;
        for (int i = 0; i < FETCH_NUM; i++) begin
            resp_mask[i] = (OFF_W'(i) >= offset_q);
        end
    end

    // PC, entry offset and queue pointers; redirect flushes the queue
    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= RESET_PC;
            offset_q <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (req_fire) offset_q <= pc[LOW_W-1:2];
            if (redirect_valid) begin
                pc     <= redirect_pc;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc     <= aligned_pc + PKT_BYTES;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage; written only on push, so no reset needed
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            q_data[wr_ptr] <= mem_resp_data;
            q_mask[wr_ptr] <= resp_mask;
            q_pc[wr_ptr]   <= aligned_pc;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] stall_cnt;

    // Count cycles where fetch is idle only because the queue is full
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((state == ST_RUN) && (count == CNT_W'(QUEUE_DEPTH)) && !redirect_valid) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit (FETCH_NUM=4, QUEUE_DEPTH=4, RESET_PC=0x100).
// Expected packets go into a scoreboard when the bench drives a response and
// are compared as decode pops them.
module tb_inst_fetch_unit;
    logic         clock = 1'b0;
    logic         reset;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_inst;
    logic [3:0]   out_mask;
    logic [31:0]  out_pc;
    logic [31:0]  perf_stall_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] inst;
        logic [3:0]   mask;
        logic [31:0]  pc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        bit          do_redir;
        logic [31:0] rpc;
        int          delay;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
    } vec_t;
    vec_t vecs[10];

    inst_fetch_unit #(
        .FETCH_NUM(4), .QUEUE_DEPTH(4), .ADDR_W(32), .RESET_PC(32'h100)
    ) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_mask(out_mask), .out_pc(out_pc),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] pkt(input logic [31:0] a);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[32*i +: 32] = 32'hA500_0000 ^ (a + 32'(4 * i));
        return d;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Sample point: scoreboard follows flush/pop exactly as the DUT will at the next edge
    task automatic to_neg();
        sb_t e;
        @(negedge clock);
        if (reset || redirect_valid) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual_pc=%0h required=no packet", out_pc);
            end else begin
                e = sb.pop_front();
                chk("out_inst", out_inst, e.inst);
                chk("out_mask", 128'(out_mask), 128'(e.mask));
                chk("out_pc", 128'(out_pc), 128'(e.pc));
            end
        end
    endtask

    task automatic to_pos();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] addr, input string nm, input bit immediate, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 20) begin
            to_neg();
            if (mem_req_valid) ok = 1'b1;
            else begin
                to_pos();
                n++;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_req_timeout actual=no request required=request", nm);
        end else begin
            chk({nm, "_addr"}, 128'(mem_req_addr), 128'(addr));
            if (immediate) chk({nm, "_req_next_cycle"}, 128'(n), 128'(0));
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [3:0] mask, input int delay,
                         input bit immediate, input string nm);
        bit ok;
        wait_req(addr, nm, immediate, ok);
        if (ok) begin
            mem_req_ready = 1'b1;
            to_pos();
            mem_req_ready = 1'b0;
            repeat (delay) begin to_neg(); to_pos(); end
            mem_resp_valid = 1'b1;
            mem_resp_data  = pkt(addr);
            sb.push_back('{inst: pkt(addr), mask: mask, pc: addr});
            to_neg();
            to_pos();
            mem_resp_valid = 1'b0;
        end
    endtask

    task automatic redir(input logic [31:0] a);
        to_neg();
        to_pos();
        redirect_valid = 1'b1;
        redirect_pc    = a;
        to_neg();
        chk("redir_req_low", 128'(mem_req_valid), 128'(0));
        to_pos();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] perf0;
        logic [31:0] exp_delta;
        bit          ok;

        vecs[0] = '{1'b0, 32'h0,        0, 32'h0000_0100, 4'b1111};
        vecs[1] = '{1'b0, 32'h0,        0, 32'h0000_0110, 4'b1111};
        vecs[2] = '{1'b0, 32'h0,        1, 32'h0000_0120, 4'b1111};
        vecs[3] = '{1'b1, 32'h208,      0, 32'h0000_0200, 4'b1100};
        vecs[4] = '{1'b0, 32'h0,        2, 32'h0000_0210, 4'b1111};
        vecs[5] = '{1'b1, 32'hFFFF_FFF0, 0, 32'hFFFF_FFF0, 4'b1111};
        vecs[6] = '{1'b0, 32'h0,        0, 32'h0000_0000, 4'b1111};
        vecs[7] = '{1'b1, 32'h30C,      1, 32'h0000_0300, 4'b1000};
        vecs[8] = '{1'b0, 32'h0,        0, 32'h0000_0310, 4'b1111};
        vecs[9] = '{1'b1, 32'h504,      0, 32'h0000_0500, 4'b1110};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        out_ready      = 1'b1;

        // reset state
        to_neg();
        chk("reset_req_valid", 128'(mem_req_valid), 128'(0));
        to_pos();
        to_neg();
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_perf", 128'(perf_stall_cnt), 128'(0));
        chk("reset_req_valid2", 128'(mem_req_valid), 128'(0));
        to_pos();
        reset = 1'b0;

        // sequential fetch, unaligned redirects, address wrap
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_redir) redir(vecs[i].rpc);
            fetch(vecs[i].exp_addr, vecs[i].exp_mask, vecs[i].delay, vecs[i].do_redir,
                  $sformatf("vec%0d", i));
        end

        // full queue: decode stalled, exactly four packets buffered
        redir(32'h1000);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            fetch(32'h1000 + 32'(16 * k), 4'b1111, 0, (k == 0), $sformatf("full%0d", k));
        to_neg();
        chk("full_req_low", 128'(mem_req_valid), 128'(0));
        chk("full_head_pc", 128'(out_pc), 128'(32'h1000));
        perf0 = perf_stall_cnt;
        for (int k = 0; k < 5; k++) begin
            to_pos();
            to_neg();
            chk("full_req_low_hold", 128'(mem_req_valid), 128'(0));
        end
`ifdef IFU_PERF_CNT_EN
        exp_delta = 32'd5;
`else
        exp_delta = 32'd0;
        chk("perf_tied_zero", 128'(perf_stall_cnt), 128'(0));
`endif
        chk("perf_stall_delta", 128'(perf_stall_cnt - perf0), 128'(exp_delta));
        to_pos();
        out_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) begin to_neg(); to_pos(); end
        chk("full_drain", 128'(sb.size()), 128'(0));

        // kill: redirect while waiting, stale response three cycles after issue
        redir(32'h2000);
        wait_req(32'h2000, "kill_pre", 1'b1, ok);
        if (ok) begin
            mem_req_ready = 1'b1;
            to_pos();
            mem_req_ready  = 1'b0;
            redirect_valid = 1'b1;
            redirect_pc    = 32'h400;
            to_neg();
            to_pos();
            redirect_valid = 1'b0;
            to_neg();
            chk("kill_req_low", 128'(mem_req_valid), 128'(0));
            to_pos();
            mem_resp_valid = 1'b1;
            mem_resp_data  = pkt(32'h2000);
            to_neg();
            to_pos();
            mem_resp_valid = 1'b0;
            to_neg();
            chk("kill_stale_dropped", 128'(out_valid), 128'(0));
            to_pos();
        end
        fetch(32'h400, 4'b1111, 0, 1'b1, "kill_next");

        // redirect coincident with the response
        redir(32'h3000);
        wait_req(32'h3000, "corner_pre", 1'b1, ok);
        if (ok) begin
            mem_req_ready = 1'b1;
            to_pos();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_data  = pkt(32'h3000);
            redirect_valid = 1'b1;
            redirect_pc    = 32'h3040;
            to_neg();
            to_pos();
            mem_resp_valid = 1'b0;
            redirect_valid = 1'b0;
            to_neg();
            chk("corner_queue_empty", 128'(out_valid), 128'(0));
            chk("corner_run_req", 128'(mem_req_valid), 128'(1));
            chk("corner_req_addr", 128'(mem_req_addr), 128'(32'h3040));
            to_pos();
        end

        // reset while a request is outstanding
        wait_req(32'h3040, "rst_pre", 1'b0, ok);
        if (ok) begin
            mem_req_ready = 1'b1;
            to_pos();
            mem_req_ready = 1'b0;
            reset = 1'b1;
            to_neg();
            chk("midwait_reset_req_low", 128'(mem_req_valid), 128'(0));
            to_pos();
            reset = 1'b0;
        end
        fetch(32'h100, 4'b1111, 0, 1'b1, "after_reset");
        for (int k = 0; k < 10 && sb.size() != 0; k++) begin to_neg(); to_pos(); end
        chk("final_drain", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
- REQ-001 SHALL have parameter FETCH_NUM, default 4, meaning instructions per fetch packet; power of two, 2..8.
- REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, meaning fetch-packet queue entries; power of two, 2 or more.
- REQ-003 SHALL have parameter ADDR_W, default 32, meaning PC width.
- REQ-004 SHALL have parameter RESET_PC, default 0, meaning PC loaded at reset.
- REQ-005 SHALL have port clock, input, 1, the only clock; all state updates on its rising edge.
- REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
- REQ-007 SHALL have port redirect_valid, input, 1, redirect request (branch or exception).
- REQ-008 SHALL have port redirect_pc, input, ADDR_W, redirect target (word aligned).
- REQ-009 SHALL have port mem_req_valid, output, 1, fetch request valid.
- REQ-010 SHALL have port mem_req_ready, input, 1, memory accepts the request.
- REQ-011 SHALL have port mem_req_addr, output, ADDR_W, packet-aligned address: pc with bits [log2(FETCH_NUM)+1:0] cleared.
- REQ-012 SHALL have port mem_resp_valid, input, 1, response valid.
- REQ-013 SHALL have port mem_resp_data, input, 32*FETCH_NUM, packet data; lane i occupies bits [32i+31:32i].
- REQ-014 SHALL have port out_valid, output, 1, queue head valid.
- REQ-015 SHALL have port out_ready, input, 1, decode accepts the head.
- REQ-016 SHALL have port out_inst, output, 32*FETCH_NUM, head packet data.
- REQ-017 SHALL have port out_mask, output, FETCH_NUM, per-lane valid bits.
- REQ-018 SHALL have port out_pc, output, ADDR_W, head packet-aligned address.
- REQ-019 SHALL have port perf_stall_cnt, output, 32, queue-full stall counter (see Configuration).

Function
- REQ-020 SHALL implement the FSM states RUN, WAIT, and KILL, with at most one memory request outstanding.
- REQ-021 In RUN, SHALL assert mem_req_valid iff queue count < QUEUE_DEPTH and redirect_valid=0; on handshake, SHALL capture the lane offset pc[log2(FETCH_NUM)+1:2] and go to WAIT.
- REQ-022 mem_req_valid and mem_req_addr SHALL be held stable until handshake, unless a redirect occurs.
- REQ-023 SHALL accept responses unconditionally (no mem_resp_ready port).
- REQ-024 In WAIT, on mem_resp_valid, SHALL push {data, mask, aligned pc}, update pc <= aligned pc + 4*FETCH_NUM (modulo 2^ADDR_W), and go to RUN.
- REQ-025 The mask for offset k SHALL set lane i iff i >= k; an offset of 0 gives all ones.
- REQ-026 On redirect_valid, SHALL flush the queue and set pc <= redirect_pc; redirect SHALL have priority over push, pop, and issue.
- REQ-027 A redirect in RUN with no handshake SHALL stay in RUN, and the next request SHALL be issued in the following cycle.
- REQ-028 A redirect in WAIT without a response SHALL go to KILL, and a redirect coincident with a req handshake SHALL also go to KILL.
- REQ-029 A redirect in WAIT coincident with mem_resp_valid SHALL drop that response and go to RUN.
- REQ-030 KILL SHALL discard the next response and then go to RUN; a redirect in KILL SHALL stay in KILL and update pc.
- REQ-031 Queue pop SHALL occur on out_valid & out_ready; a simultaneous push and pop SHALL leave the count unchanged.
- REQ-032 The queue SHALL never overflow; the one-outstanding rule together with REQ-021 guarantees space.
- REQ-033 out_* SHALL be driven from the queue head combinationally; out_valid=0 when the queue is empty, and out_inst, out_mask and out_pc are don't-care.
- REQ-034 Head-to-out latency SHALL be 0 cycles; response-to-out_valid latency SHALL be 1 cycle.

Reset
- REQ-035 On reset: pc=RESET_PC, state=RUN, queue empty, out_valid=0, mem_req_valid=0 in the reset cycle, perf_stall_cnt=0.
- REQ-036 Reset mid-WAIT SHALL return to RUN; any response arriving after reset for a pre-reset request is the memory's responsibility and SHALL NOT be filtered.

Configuration
- REQ-037 With IFU_PERF_CNT_EN defined, perf_stall_cnt SHALL increment (wrapping) each cycle in RUN with queue count == QUEUE_DEPTH and no redirect.
- REQ-038 Without IFU_PERF_CNT_EN, perf_stall_cnt SHALL be constant 0 and no counter logic SHALL be generated.

Verification
- REQ-039 Reset test: RESET_PC=0x100, FETCH_NUM=4, out_ready=1, memory ready with 1-cycle responses -> requests go to 0x100, 0x110, 0x120, ...; out_mask=4'b1111 throughout.
- REQ-040 Unaligned redirect test: redirect_pc=0x208 -> next req addr 0x200 and out_mask=4'b1100; the following packet goes to 0x210 with mask 4'b1111.
- REQ-041 Full-queue test: out_ready=0 -> exactly QUEUE_DEPTH packets are queued, mem_req_valid stays low, and perf_stall_cnt counts stall cycles with IFU_PERF_CNT_EN (0 without).
- REQ-042 Kill test: redirect to 0x400 while in WAIT with the response delayed 3 cycles -> the stale response is dropped, the next req is 0x400, and no stale packet reaches out.
- REQ-043 Corner test: redirect in the same cycle as mem_resp_valid -> the response is dropped, state is RUN, and the queue is empty.
- REQ-044 Wrap test: with ADDR_W=32, pc=0xFFFFFFF0 -> the next req addr is 0x00000000.
